// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared fp32 widths, mantissa bit positions, FSM states and pack constants
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int MANX_W = MAN_W + 5;

  localparam logic [EXP_W:0] BIAS    = 9'd127;
  localparam logic [EXP_W:0] EXP_MAX = 9'd255;
  localparam logic [EXP_W:0] EXP_ONE = 9'd1;

  // Extended mantissa layout: carry, hidden, fraction, guard, round, sticky
  localparam int CARRY  = MANX_W - 1;
  localparam int HIDDEN = MANX_W - 2;
  localparam int L_BIT  = 3;
  localparam int G_BIT  = 2;
  localparam int R_BIT  = 1;
  localparam int S_BIT  = 0;

  localparam logic [31:0] QNAN_PACK = 32'h7FC0_0000;
  localparam logic [31:0] INF_PACK  = 32'h7F80_0000;
  localparam logic [31:0] ZERO_PACK = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // What a single NORM cycle decides to do, in priority order
  typedef enum logic [2:0] {
    NA_ZERO   = 3'd0,
    NA_INF    = 3'd1,
    NA_UNF    = 3'd2,
    NA_RSHIFT = 3'd3,
    NA_READY  = 3'd4,
    NA_LSHIFT = 3'd5
  } norm_act_t;

endpackage

// File: rtl/fp_normalize_round_if.sv
// rtl/fp_normalize_round_if.sv - operand/result handshake bundle for the normalize/round stage
interface fp_normalize_round_if;
  import fp32_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANX_W-1:0] in_mant;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic              out_overflow;
  logic              out_underflow;
  logic              out_zero;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_zero
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_zero
  );

endinterface

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even increment with mantissa carry-out detection
module fp_round_rne
  import fp32_pkg::*;
(
  input  logic [MANX_W-1:0] mant,
  output logic [MAN_W-1:0]  frac,
  output logic              carry
);

  logic             inc;
  logic [MAN_W+1:0] sum;

  // Round up when above half, or exactly half with an odd LSB; renormalize on carry
  always_comb begin
    inc   = mant[G_BIT] & (mant[L_BIT] | mant[R_BIT] | mant[S_BIT]);
    sum   = mant[CARRY:L_BIT] + {{(MAN_W+1){1'b0}}, inc};
    carry = sum[MAN_W+1];
    frac  = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
  end

endmodule

// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - iterative fp32 normalize, RNE round and pack
module fp_normalize_round
  import fp32_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  fp_normalize_round_if.slave  io
);

  state_t            state_q, state_d;
  norm_act_t         act;
  logic              sign_q;
  logic [EXP_W:0]    exp_q;
  logic [MANX_W-1:0] mant_q;
  logic [31:0]       result_q;
  logic              ovf_q, unf_q, zero_q;

  logic [MAN_W-1:0]  rnd_frac;
  logic              rnd_carry;
  logic [EXP_W:0]    rnd_exp;

  fp_round_rne u_round (
    .mant  (mant_q),
    .frac  (rnd_frac),
    .carry (rnd_carry)
  );

  // Exponent after a possible rounding carry; the extra bit keeps overflow visible
  always_comb begin
    rnd_exp = exp_q + {{EXP_W{1'b0}}, rnd_carry};
  end

  // Classify the current NORM cycle; special cases take priority over shifting
  always_comb begin
    if (mant_q == '0)              act = NA_ZERO;
    else if (exp_q == EXP_MAX)     act = NA_INF;
    else if (exp_q == '0)          act = NA_UNF;
    else if (mant_q[CARRY])        act = NA_RSHIFT;
    else if (mant_q[HIDDEN])       act = NA_READY;
    else if (exp_q == EXP_ONE)     act = NA_UNF;
    else                           act = NA_LSHIFT;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (io.in_valid) state_d = ST_NORM;
      ST_NORM: begin
        case (act)
          NA_ZERO, NA_INF, NA_UNF: state_d = ST_DONE;
          NA_RSHIFT, NA_READY:     state_d = ST_ROUND;
          default:                 state_d = ST_NORM;
        endcase
      end
      ST_ROUND: state_d = ST_DONE;
      ST_DONE:  if (io.out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: handshakes decode the state, result and flags come from registers
  always_comb begin
    io.in_ready      = (state_q == ST_IDLE);
    io.out_valid     = (state_q == ST_DONE);
    io.out_result    = result_q;
    io.out_overflow  = ovf_q;
    io.out_underflow = unf_q;
    io.out_zero      = zero_q;
  end

  // Operand capture, one-bit-per-cycle normalization, rounding and result packing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= ZERO_PACK;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.in_valid) begin
            sign_q <= io.in_sign;
            exp_q  <= {1'b0, io.in_exp};
            mant_q <= io.in_mant;
          end
        end
        ST_NORM: begin
          case (act)
            NA_ZERO: begin
              result_q <= {sign_q, ZERO_PACK[30:0]};
              zero_q   <= 1'b1;
            end
            NA_INF: begin
              result_q <= {sign_q, INF_PACK[30:0]};
              ovf_q    <= 1'b1;
            end
            NA_UNF: begin
              result_q <= {sign_q, ZERO_PACK[30:0]};
              unf_q    <= 1'b1;
            end
            NA_RSHIFT: begin
              // Bit shifted out is folded into sticky so it still counts for rounding
              mant_q <= {1'b0, mant_q[CARRY:2], mant_q[R_BIT] | mant_q[S_BIT]};
              exp_q  <= exp_q + EXP_ONE;
            end
            NA_LSHIFT: begin
              // Sticky stays set while the rest of the mantissa moves up
              mant_q <= {mant_q[HIDDEN:1], mant_q[S_BIT], mant_q[S_BIT]};
              exp_q  <= exp_q - EXP_ONE;
            end
            default: ;
          endcase
        end
        ST_ROUND: begin
          if (rnd_exp >= EXP_MAX) begin
            result_q <= {sign_q, INF_PACK[30:0]};
            ovf_q    <= 1'b1;
          end else begin
            result_q <= {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
          end
        end
        ST_DONE: begin
          if (io.out_ready) begin
            result_q <= ZERO_PACK;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            zero_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
